// File: rtl/strobe_period_meter_if.sv
// Result bus of strobe_period_meter: measured count with valid/ready handshake.
// The master side (the meter) drives count, count_valid and overflow; the
// slave side (the consumer) drives out_ready.
interface strobe_period_meter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic             overflow;
  logic             out_ready;

  modport master (
    output count,
    output count_valid,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  count,
    input  count_valid,
    input  overflow,
    output out_ready
  );
endinterface

// File: rtl/strobe_period_meter.sv
// strobe_period_meter: counts enable ticks between consecutive strobe_in
// pulses and presents each period on a valid/ready result bus.
// The optional min/max tracker is built when STROBE_PERIOD_METER_MINMAX_EN
// is defined; without it the min_count/max_count ports do not exist.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset, waiting for the first strobe; ticks ignored
// ST_MEASURE | counting ticks; each strobe closes one period
module strobe_period_meter #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        strobe_in,
  strobe_period_meter_if.master       res,
  output logic                        overrun,
  output logic                        locked
`ifdef STROBE_PERIOD_METER_MINMAX_EN
  ,
  output logic [WIDTH-1:0]            min_count,
  output logic [WIDTH-1:0]            max_count
`endif
);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] TICK_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ticks_q, ticks_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;

  logic             new_res;
  logic [WIDTH-1:0] res_val;
  logic [WIDTH-1:0] ticks_inc;

  // State and result registers; reset discards any partial or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ticks_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ticks_q   <= ticks_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state and tick counter; a strobe in MEASURE closes the period,
  // counting a coincident enable, and restarts the counter from zero.
  always_comb begin
    state_d   = state_q;
    ticks_d   = ticks_q;
    new_res   = 1'b0;
    res_val   = '0;
    ticks_inc = (enable && (ticks_q != TICK_MAX)) ? ticks_q + WIDTH'(1) : ticks_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe_in) begin
          state_d = ST_MEASURE;
          ticks_d = '0;
        end
      end
      ST_MEASURE: begin
        if (strobe_in) begin
          new_res = 1'b1;
          res_val = ticks_inc;
          ticks_d = '0;
        end else begin
          ticks_d = ticks_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ticks_d = '0;
      end
    endcase
  end

  // Result holding register: a new result loads if the slot is empty or
  // being accepted this cycle, otherwise it is dropped with an overrun pulse.
  always_comb begin
    count_d   = count_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = 1'b0;
    if (new_res) begin
      if (!valid_q || res.out_ready) begin
        count_d = res_val;
        valid_d = 1'b1;
        ovf_d   = (res_val == TICK_MAX);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && res.out_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef STROBE_PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  // Extremes registers; dropped results still count toward min/max.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // Extremes update in the cycle a result is produced.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (new_res) begin
      if (res_val < min_q) min_d = res_val;
      if (res_val > max_q) max_d = res_val;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`endif

  assign res.count       = count_q;
  assign res.count_valid = valid_q;
  assign res.overflow    = ovf_q;
  assign overrun         = overrun_q;
  assign locked          = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_strobe_period_meter.sv
// Bench for strobe_period_meter: a WIDTH=8 and a WIDTH=4 instance share the
// same stimulus. A reference model tracks raw (unbounded) tick counts and
// saturates them per width only when forming expectations.
module tb_strobe_period_meter;

  logic clk = 1'b0;
  logic rst, enable, strobe_in, out_ready;
  logic overrun8, locked8, overrun4, locked4;

  int checks = 0;
  int errors = 0;

  strobe_period_meter_if #(.WIDTH(8)) if8 ();
  strobe_period_meter_if #(.WIDTH(4)) if4 ();
  assign if8.out_ready = out_ready;
  assign if4.out_ready = out_ready;

`ifdef STROBE_PERIOD_METER_MINMAX_EN
  logic [7:0] min8, max8;
  logic [3:0] min4, max4;
`endif

  strobe_period_meter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .strobe_in(strobe_in),
    .res(if8.master), .overrun(overrun8), .locked(locked8)
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    , .min_count(min8), .max_count(max8)
`endif
  );

  strobe_period_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .strobe_in(strobe_in),
    .res(if4.master), .overrun(overrun4), .locked(locked4)
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    , .min_count(min4), .max_count(max4)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state (raw, unsaturated tick counts).
  bit m_locked, m_valid, m_overrun;
  int m_ticks, m_held, m_min, m_max;

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_valid = 0; m_overrun = 0;
    m_ticks = 0; m_held = 0; m_min = 1 << 30; m_max = 0;
  endtask

  task automatic model_update(input bit r, input bit e, input bit s, input bit y);
    bit produced;
    int period;
    produced = 0;
    period = 0;
    if (r) begin
      model_reset();
    end else begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_ticks = 0;
        end
      end else begin
        if (e) m_ticks++;
        if (s) begin
          produced = 1;
          period = m_ticks;
          m_ticks = 0;
        end
      end
      m_overrun = 0;
      if (produced) begin
        if (period < m_min) m_min = period;
        if (period > m_max) m_max = period;
        if (!m_valid || y) begin
          m_held = period;
          m_valid = 1;
        end else begin
          m_overrun = 1;
        end
      end else if (m_valid && y) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_model();
    chk("count8", int'(if8.count), sat(m_held, 8));
    chk("valid8", int'(if8.count_valid), int'(m_valid));
    chk("ovf8", int'(if8.overflow), int'(m_held >= 255));
    chk("overrun8", int'(overrun8), int'(m_overrun));
    chk("locked8", int'(locked8), int'(m_locked));
    chk("count4", int'(if4.count), sat(m_held, 4));
    chk("valid4", int'(if4.count_valid), int'(m_valid));
    chk("ovf4", int'(if4.overflow), int'(m_held >= 15));
    chk("overrun4", int'(overrun4), int'(m_overrun));
    chk("locked4", int'(locked4), int'(m_locked));
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    chk("min8", int'(min8), sat(m_min, 8));
    chk("max8", int'(max8), sat(m_max, 8));
    chk("min4", int'(min4), sat(m_min, 4));
    chk("max4", int'(max4), sat(m_max, 4));
`endif
  endtask

  // One clock: drive inputs, take the edge, then compare 1 time unit later.
  task automatic step(input bit r, input bit e, input bit s, input bit y);
    rst = r; enable = e; strobe_in = s; out_ready = y;
    @(posedge clk);
    model_update(r, e, s, y);
    #1;
    compare_model();
  endtask

  task automatic run_enables(input int n, input bit y);
    for (int i = 0; i < n; i++) step(0, 1, 0, y);
  endtask

  typedef struct {
    bit       r, e, s, y;
    bit [7:0] e_count;
    bit       e_valid, e_ovf, e_overrun, e_locked;
  } vec_t;

  vec_t vecs[15];

  initial begin
    rst = 1; enable = 0; strobe_in = 0; out_ready = 0;
    model_reset();

    // r e s y | count valid ovf overrun locked
    vecs[0]  = '{1,0,0,0, 8'd0, 0,0,0,0};
    vecs[1]  = '{0,0,1,0, 8'd0, 0,0,0,1};
    vecs[2]  = '{0,1,0,0, 8'd0, 0,0,0,1};
    vecs[3]  = '{0,0,0,0, 8'd0, 0,0,0,1};
    vecs[4]  = '{0,1,0,0, 8'd0, 0,0,0,1};
    vecs[5]  = '{0,0,0,0, 8'd0, 0,0,0,1};
    vecs[6]  = '{0,1,0,0, 8'd0, 0,0,0,1};
    vecs[7]  = '{0,0,1,0, 8'd3, 1,0,0,1};
    vecs[8]  = '{0,0,0,1, 8'd3, 0,0,0,1};
    vecs[9]  = '{0,1,0,0, 8'd3, 0,0,0,1};
    vecs[10] = '{0,1,0,0, 8'd3, 0,0,0,1};
    vecs[11] = '{0,1,0,0, 8'd3, 0,0,0,1};
    vecs[12] = '{0,1,0,0, 8'd3, 0,0,0,1};
    vecs[13] = '{0,1,1,0, 8'd5, 1,0,0,1};
    vecs[14] = '{0,0,0,1, 8'd5, 0,0,0,1};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].y);
      chk($sformatf("vec%0d_count", i), int'(if8.count), int'(vecs[i].e_count));
      chk($sformatf("vec%0d_valid", i), int'(if8.count_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_ovf", i), int'(if8.overflow), int'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_overrun", i), int'(overrun8), int'(vecs[i].e_overrun));
      chk($sformatf("vec%0d_locked", i), int'(locked8), int'(vecs[i].e_locked));
    end

    // 20 ticks: WIDTH=4 saturates at 15 with overflow, WIDTH=8 does not.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    run_enables(20, 0);
    step(0, 0, 1, 0);
    chk("sat4_count", int'(if4.count), 15);
    chk("sat4_ovf", int'(if4.overflow), 1);
    chk("sat8_count", int'(if8.count), 20);
    chk("sat8_ovf", int'(if8.overflow), 0);

    // 300 ticks saturate WIDTH=8.
    step(0, 0, 0, 1);
    run_enables(300, 0);
    step(0, 0, 1, 0);
    chk("sat255_count", int'(if8.count), 255);
    chk("sat255_ovf", int'(if8.overflow), 1);

    // Hold, drop with overrun, then load on the accept cycle.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    run_enables(4, 0);
    step(0, 0, 1, 0);
    chk("hold_first", int'(if8.count), 4);
    run_enables(2, 0);
    step(0, 0, 1, 0);
    chk("drop_count", int'(if8.count), 4);
    chk("drop_overrun", int'(overrun8), 1);
    step(0, 0, 0, 0);
    chk("overrun_1cyc", int'(overrun8), 0);
    chk("drop_still_valid", int'(if8.count_valid), 1);
    run_enables(6, 0);
    step(0, 0, 1, 1);
    chk("accept_load_count", int'(if8.count), 6);
    chk("accept_load_valid", int'(if8.count_valid), 1);
    chk("accept_load_overrun", int'(overrun8), 0);

    // Back-to-back strobes with zero ticks between them.
    step(0, 0, 1, 1);
    chk("zero_count", int'(if8.count), 0);
    chk("zero_ovf", int'(if8.overflow), 0);
    chk("zero_valid", int'(if8.count_valid), 1);
    step(0, 0, 1, 1);
    chk("b2b_valid", int'(if8.count_valid), 1);

    // Reset mid-measurement with a held result.
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_count", int'(if8.count), 0);
    chk("rst_valid", int'(if8.count_valid), 0);
    chk("rst_locked", int'(locked8), 0);
    step(0, 1, 1, 0);
    chk("rst_first_noresult", int'(if8.count_valid), 0);
    chk("rst_first_locked", int'(locked8), 1);

`ifdef STROBE_PERIOD_METER_MINMAX_EN
    // Results 7, 2, 9.
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    run_enables(7, 1);
    step(0, 0, 1, 1);
    run_enables(2, 1);
    step(0, 0, 1, 1);
    run_enables(9, 1);
    step(0, 0, 1, 1);
    chk("minmax_min", int'(min8), 2);
    chk("minmax_max", int'(max8), 9);
`endif

    // Randomized stimulus against the model.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, e, s, y;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 1) == 1);
      if (i % 1000 < 500) s = ($urandom_range(0, 7) == 0);
      else                s = ($urandom_range(0, 29) == 0);
      y = ($urandom_range(0, 2) != 0);
      step(r, e, s, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
